// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - behavioural DRAM controller app-port responder with calibration delay and fixed read latency
// Optional feature macro: DRAM_RESPONDER_STALL_EN (LFSR-driven busy injection while idle)
module dram_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int CALIB_CYCLES   = 64,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ren,
  input  logic                      i_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic [APP_MASK_WIDTH-1:0] i_mask,
  input  logic                      i_busy,
  output logic                      o_init_calib_complete,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy
);

  localparam int LINES = 1 << MEM_LINES_LOG2;
  localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    CALIB,
    IDLE,
    READ_WAIT,
    READ_RESP
  } state_t;

  state_t                      state;
  logic [CAL_W-1:0]            cal_cnt;
  logic [LAT_W-1:0]            lat_cnt;
  logic [APP_DATA_WIDTH-1:0]   rd_line;
  logic [APP_DATA_WIDTH-1:0]   mem [LINES];

  logic [MEM_LINES_LOG2-1:0]   line_idx;
  logic                        cmd_ok;
  logic                        wr_fire;
  logic                        rd_fire;
  logic                        stall_next;
  logic                        unused_addr_bits;

  // Column address is in 16-bit units, eight per line; bits above the store depth wrap
  assign line_idx = i_addr[MEM_LINES_LOG2+2:3];
  assign unused_addr_bits = ^{i_addr[2:0], i_addr[APP_ADDR_WIDTH-2:MEM_LINES_LOG2+3]};

  // A command is taken only in an idle, non-busy cycle; a write wins over a simultaneous read
  assign cmd_ok  = !rst && !o_busy && (state == IDLE);
  assign wr_fire = cmd_ok && i_wen;
  assign rd_fire = cmd_ok && i_ren && !i_wen;

`ifdef DRAM_RESPONDER_STALL_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, held at its seed until calibration finishes
  always_comb begin
    lfsr_next = lfsr;
    if (state != CALIB) begin
      lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // LFSR state register; the value it holds in a cycle decides that cycle's stall
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  assign stall_next = (lfsr_next[1:0] == 2'b00);
`else
  assign stall_next = 1'b0;
`endif

  // Backing store: byte-masked line write at the accepting edge, never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!i_mask[b]) begin
          mem[line_idx][b*8 +: 8] <= i_data[b*8 +: 8];
        end
      end
    end
  end

  // Responder FSM: calibration countdown, read capture, latency wait and held response
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= CALIB;
      cal_cnt               <= '0;
      lat_cnt               <= '0;
      rd_line               <= '0;
      o_init_calib_complete <= 1'b0;
      o_busy                <= 1'b1;
      o_data_valid          <= 1'b0;
      o_data                <= '0;
    end else begin
      case (state)
        CALIB: begin
          if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
            state                 <= IDLE;
            o_init_calib_complete <= 1'b1;
            o_busy                <= stall_next;
          end else begin
            cal_cnt <= cal_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rd_fire) begin
            // Snapshot now so the response reflects the store as of this edge
            rd_line <= mem[line_idx];
            lat_cnt <= '0;
            state   <= READ_WAIT;
            o_busy  <= 1'b1;
          end else begin
            o_busy <= stall_next;
          end
        end
        READ_WAIT: begin
          if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            o_data       <= rd_line;
            o_data_valid <= 1'b1;
            state        <= READ_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        READ_RESP: begin
          if (!i_busy) begin
            o_data_valid <= 1'b0;
            state        <= IDLE;
            o_busy       <= stall_next;
          end
        end
        default: begin
          state  <= CALIB;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter APP_ADDR_WIDTH, default 28: controller app address width; command address is APP_ADDR_WIDTH-1 bits.
REQ-002 SHALL have parameter APP_DATA_WIDTH, default 128: line width in bits.
REQ-003 SHALL have parameter APP_MASK_WIDTH, default 16: byte-mask width, APP_DATA_WIDTH/8.
REQ-004 SHALL have parameter MEM_LINES_LOG2, default 10: log2 of backing-store depth in lines.
REQ-005 SHALL have parameter CALIB_CYCLES, default 64: post-reset cycles before calibration completes.
REQ-006 SHALL have parameter READ_LATENCY, default 4: cycles from read acceptance to first o_data_valid, minimum 1.
REQ-007 SHALL have a single clock clk and reset rst; rst is synchronous and active-high.
REQ-008 SHALL have the following ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_ren  input  1  read command request
- i_wen  input  1  write command request
- i_addr  input  APP_ADDR_WIDTH-1  column address, 16-bit units
- i_data  input  APP_DATA_WIDTH  write line data
- i_mask  input  APP_MASK_WIDTH  byte mask; 1 = byte not written
- i_busy  input  1  initiator cannot accept read data
- o_init_calib_complete  output  1  calibration done
- o_data  output  APP_DATA_WIDTH  read line data
- o_data_valid  output  1  o_data valid this cycle
- o_busy  output  1  command not accepted this cycle

Function
REQ-009 SHALL implement states CALIB, IDLE, READ_WAIT, READ_RESP.
REQ-010 SHALL remain in CALIB for exactly CALIB_CYCLES cycles after rst deasserts, then enter IDLE and assert o_init_calib_complete, which stays high until the next reset.
REQ-011 SHALL drive o_busy high in CALIB, READ_WAIT and READ_RESP, and low in IDLE except as required by REQ-024.
REQ-012 SHALL accept a command on a rising edge where (i_ren or i_wen) and o_busy is low; requests while o_busy is high are ignored and not queued.
REQ-013 SHALL compute the line index as i_addr[MEM_LINES_LOG2+2:3], ignore i_addr[2:0], and wrap higher address bits silently.
REQ-014 SHALL commit an accepted write at the accepting edge, updating only bytes whose i_mask bit is 0, and remain in IDLE so back-to-back writes are accepted every cycle.
REQ-015 SHALL give i_wen priority when i_ren and i_wen are both high; the read is dropped.
REQ-016 SHALL, on an accepted read, capture the line and enter READ_WAIT with a latency counter, so o_data_valid first rises exactly READ_LATENCY cycles after the accepting edge.
REQ-017 SHALL return the line contents as of the accepting edge, including a write accepted on the immediately preceding edge.
REQ-018 SHALL, in READ_RESP, hold o_data and o_data_valid stable while i_busy is high, and return to IDLE on the edge where o_data_valid and !i_busy.
REQ-019 SHALL pulse o_data_valid for exactly one cycle per read when i_busy is low.
REQ-020 SHALL keep o_data at its last value outside READ_RESP.

Reset
REQ-021 SHALL on rst set state CALIB, o_init_calib_complete 0, o_busy 1, o_data_valid 0, o_data 0, and clear the calibration and latency counters.
REQ-022 SHALL, on rst mid-read, abort the read with no o_data_valid pulse and restart full calibration.
REQ-023 SHALL NOT reset backing-store contents.

Configuration
REQ-024 SHALL, with DRAM_RESPONDER_STALL_EN defined, run an 8-bit LFSR (seed 8'hA5, polynomial x^8+x^6+x^5+x^4+1) advancing every cycle after calibration; in IDLE, when lfsr[1:0]==2'b00, o_busy is high that cycle and no command is accepted.
REQ-025 SHALL, without DRAM_RESPONDER_STALL_EN, have no LFSR and no injected busy cycles.

Verification
REQ-026 Reset, then idle for 63 and 64 cycles -> o_init_calib_complete 0 after 63, 1 after 64; o_busy falls on that same cycle.
REQ-027 Write 128'h0123..CDEF at addr 0x10 with mask 16'h0000, then read at 0x17 -> identical line; o_data_valid one cycle, 4 cycles after acceptance.
REQ-028 Write all-FF, then write all-00 with mask 16'hFFF0, then read -> low 4 bytes 00, rest FF.
REQ-029 Read with i_busy high for 3 cycles at response -> o_data_valid held 3+1 cycles, data stable, o_busy high throughout.
REQ-030 Simultaneous i_ren=1, i_wen=1 -> write committed, no o_data_valid; rst asserted 2 cycles into a read -> no valid, recalibrates for 64 cycles.
REQ-031 Address 2^(MEM_LINES_LOG2+3) -> aliases line 0; with DRAM_RESPONDER_STALL_EN, 1000 random commands -> all writes and reads are accepted only when o_busy is low, and every read returns the last written data.
